// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction fetch memory:
//                fault codes, the pipeline stage record, the word returned for
//                faulted fetches and the PC fault classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Fault codes carried alongside every fetch
    localparam logic [1:0]  FAULT_NONE       = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN   = 2'b01;
    localparam logic [1:0]  FAULT_RANGE      = 2'b10;

    // Word delivered in place of an instruction when the fetch faulted
    localparam logic [31:0] INSTR_FAULT_WORD = 32'h0000_0000;

    // One pipeline stage: everything the response channel needs
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } fetch_stage_t;

    // Classify a byte address against the last legal word address.
    // Misalignment is reported in preference to range; the compare is a
    // full 32-bit unsigned compare so addresses never wrap into storage.
    function automatic logic [1:0] decode_fault(
        input logic [31:0] pc,
        input logic [31:0] last_word
    );
        logic [1:0] f;
        f = FAULT_NONE;
        if (pc[1:0] != 2'b00) begin
            f = FAULT_MISALIGN;
        end else if (pc > last_word) begin
            f = FAULT_RANGE;
        end
        return f;
    endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_byte_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_array
//  Description : Byte-organised instruction storage with a combinational
//                big-endian word read port. When IMEM_PROG_PORT_EN is defined
//                a synchronous big-endian word write port is present; a read
//                of the word being written returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_array
    import imem_pkg::*;
#(
    parameter int    DEPTH_BYTES = 256,
    parameter string INIT_FILE   = "",
    parameter int    WAW         = $clog2(DEPTH_BYTES) - 2
) (
    input  logic           clk,
    input  logic [WAW-1:0] i_rd_word,
    output logic [31:0]    o_rd_data
`ifdef IMEM_PROG_PORT_EN
    ,
    input  logic           i_wr_en,
    input  logic [WAW-1:0] i_wr_word,
    input  logic [31:0]    i_wr_data
`endif
);

    logic [7:0] r_mem [DEPTH_BYTES];

    // Big-endian word assembly: lowest byte address is the most significant byte
    assign o_rd_data = {r_mem[{i_rd_word, 2'b00}],
                        r_mem[{i_rd_word, 2'b01}],
                        r_mem[{i_rd_word, 2'b10}],
                        r_mem[{i_rd_word, 2'b11}]};

`ifdef IMEM_PROG_PORT_EN
    // Word write, big-endian byte placement; legality is decided by the caller
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_word, 2'b00}] <= i_wr_data[31:24];
            r_mem[{i_wr_word, 2'b01}] <= i_wr_data[23:16];
            r_mem[{i_wr_word, 2'b10}] <= i_wr_data[15:8];
            r_mem[{i_wr_word, 2'b11}] <= i_wr_data[7:0];
        end
    end
`endif

endmodule : imem_byte_array
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_mem
//  Description : Pipelined instruction memory for the RV32I fetch stage.
//                Valid/ready request (byte PC) and response (instruction, PC,
//                fault) channels, LATENCY stages (1 or 2), global stall when
//                the response is not taken, flush for branch redirects, and
//                misaligned / out-of-range fault reporting.
//                Optional feature macro: IMEM_PROG_PORT_EN adds the
//                prog_we / prog_addr / prog_wdata write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int    DEPTH_BYTES = 256,   // multiple of 4, power of two, >= 8
    parameter int    LATENCY     = 1,     // legal values 1 or 2
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic [31:0] resp_pc,
    output logic [1:0]  resp_fault
`ifdef IMEM_PROG_PORT_EN
    ,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
`endif
);

    localparam int          AW          = $clog2(DEPTH_BYTES);
    localparam int          WAW         = AW - 2;
    localparam logic [31:0] C_LAST_WORD = 32'(DEPTH_BYTES - 4);

    fetch_stage_t   r_stage [LATENCY];
    fetch_stage_t   w_last;
    fetch_stage_t   w_new;
    logic [1:0]     w_req_fault;
    logic [31:0]    w_rd_data;
    logic           w_advance;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
`ifdef IMEM_PROG_PORT_EN
    logic           w_wr_en;

    // Writes that are misaligned or beyond the last word are dropped here
    assign w_wr_en = prog_we && (decode_fault(prog_addr, C_LAST_WORD) == FAULT_NONE);
`endif

    imem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .INIT_FILE   (INIT_FILE),
        .WAW         (WAW)
    ) u_mem (
        .clk        (clk),
        .i_rd_word  (req_pc[AW-1:2]),
        .o_rd_data  (w_rd_data)
`ifdef IMEM_PROG_PORT_EN
        ,
        .i_wr_en    (w_wr_en),
        .i_wr_word  (prog_addr[AW-1:2]),
        .i_wr_data  (prog_wdata)
`endif
    );

    // ------------------------------------------------------------------
    // Request side: fault decode and stage-1 record
    // ------------------------------------------------------------------
    assign w_req_fault = decode_fault(req_pc, C_LAST_WORD);

    // Build the record that enters stage 1; faulted fetches carry the fixed word
    always_comb begin
        w_new       = '0;
        w_new.valid = req_valid;
        w_new.pc    = req_pc;
        w_new.fault = w_req_fault;
        w_new.instr = (w_req_fault == FAULT_NONE) ? w_rd_data : INSTR_FAULT_WORD;
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign w_last    = r_stage[LATENCY-1];
    assign w_advance = !w_last.valid || resp_ready;

    // A redirect must always be able to enter, even behind a stalled output
    assign req_ready = (w_advance || flush) && reset_n;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    // Shift on advance, drop everything in flight on flush, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (flush) begin
            r_stage[0] <= w_new;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i].valid <= 1'b0;
            end
        end else if (w_advance) begin
            r_stage[0] <= w_new;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response channel driven straight from the last stage
    // ------------------------------------------------------------------
    assign resp_valid = w_last.valid;
    assign resp_instr = w_last.instr;
    assign resp_pc    = w_last.pc;
    assign resp_fault = w_last.fault;

endmodule : instr_fetch_mem
`default_nettype wire
